nn_layer_sequencer: RTL
=======================

// Module: nn_layer_sequencer
// PURPOSE
//  Sequences the combinational NN layer datapath (12 x 10-bit inputs -> 10 x 12-bit outputs).
//  Collects one input vector as a serial valid/ready stream and holds it on the layer inputs.
//  Waits a fixed settle time, then captures the layer outputs and drains them as a serial
//  valid/ready stream. One vector is in flight at a time.
// PARAMETERS
//  IN_W    10  width of one layer input word
//  OUT_W   12  width of one layer output word
//  N_IN    12  input words per vector
//  N_OUT   10  output words per vector
//  SETTLE  2   cycles the datapath is given to settle after the last input; legal range 1..15
// PORTS
//  clk        in   1            single clock, all logic rising-edge
//  rst        in   1            synchronous reset, active-high
//  in_valid   in   1            input word valid
//  in_ready   out  1            sequencer accepts an input word
//  in_data    in   IN_W         input word; slot = arrival order (0 = in1)
//  in_last    in   1            marks the final word of a vector
//  layer_in   out  N_IN*IN_W    to datapath; slot k at [k*IN_W +: IN_W]
//  layer_out  in   N_OUT*OUT_W  from datapath; slot k at [k*OUT_W +: OUT_W]
//  out_valid  out  1            output word valid
//  out_ready  in   1            consumer accepts an output word
//  out_data   out  OUT_W        output word
//  out_idx    out  4            slot of out_data (0..N_OUT-1)
//  out_last   out  1            high with the word at slot N_OUT-1
//  busy       out  1            high in SETTLE, CAPTURE and DRAIN
//  err        out  1            one-cycle pulse on an in_last framing error
// BEHAVIOUR
//  Reset values: state=LOAD, in_idx=0, out_idx=0, layer_in=0, capture regs=0.
//    Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, err=0.
//  Reset mid-operation takes effect next cycle from any state. Any partial vector or undrained
//    output is discarded.
//  FSM LOAD -> SETTLE -> CAPTURE -> DRAIN -> LOAD.
//  LOAD:
//    - in_ready=1.
//    - Each in_valid&in_ready beat writes layer_in slot in_idx; in_idx increments.
//    - Beat with in_idx==N_IN-1 and in_last=1: go to SETTLE, cnt=SETTLE, in_idx=0.
//    - Framing error: in_last=1 with in_idx<N_IN-1, or in_last=0 with in_idx==N_IN-1.
//      Registered err=1 for one cycle, in_idx=0, stay in LOAD. No compute.
//      Slots already written keep their values until overwritten.
//  SETTLE:
//    - in_ready=0, layer_in held stable, cnt decrements each cycle.
//    - Occupies exactly SETTLE cycles.
//  CAPTURE:
//    - One cycle. Registers all of layer_out into the capture regs.
//  DRAIN:
//    - out_valid=1, out_data=capture[out_idx], out_last=(out_idx==N_OUT-1).
//    - Each out_valid&out_ready increments out_idx.
//    - While out_ready=0, out_data, out_idx and out_last are held stable.
//    - Handshake on the last word: out_idx=0, next state LOAD, in_ready=1 the following cycle.
//  Latency: last input beat accepted at edge t -> layer_out captured at edge t+SETTLE+1
//    -> out_valid high from cycle t+SETTLE+2.
//    With out_ready held at 1, a vector takes N_IN + SETTLE + 1 + N_OUT cycles.
//  No arithmetic: words pass through zero-width-change; layer_in is driven only from registers.
// TESTING (bench stub: layer_out[k] = {2'b0,in[k]} + {2'b0,in[k+2]}, in[12],in[13]=0)
//  1 Vector in4=0xC4,in5=0x19,in11=0x88,in12=0x8B (others 0), SETTLE=2, out_ready=1
//    -> out = 0,0xC4,0x19,0xC4,0x19,0,0,0,0x88,0x8B.
//    -> out_last only with word 10; first out_valid at t+4.
//  2 Same vector, out_ready toggled 1,0,0,1,...
//    -> out_data/out_idx held while stalled; exactly 10 handshakes; in_ready low until the last.
//  3 in_last=1 on the 5th word -> err pulses 1 cycle, no out_valid.
//    Then a full valid vector -> correct 10 outputs.
//  4 12 words with in_last=0 on the 12th -> err pulse, stays in LOAD, busy stays 0.
//  5 rst asserted in DRAIN after 3 outputs -> next cycle out_valid=0, in_ready=1, layer_in=0.
//    A new vector then drains from out_idx 0.
//  6 Back-to-back: 30 vectors streamed with in_valid held high -> every vector's 10 outputs
//    match the stub; none dropped or duplicated.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Serial-in / serial-out wrapper around a combinational NN layer datapath:
// gathers one input vector, lets the datapath settle, captures and drains the results.
module nn_layer_sequencer #(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 12,
    parameter int N_IN   = 12,
    parameter int N_OUT  = 10,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_last,
    output logic [N_IN*IN_W-1:0]   layer_in,
    input  logic [N_OUT*OUT_W-1:0] layer_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [3:0]             out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err
);
    localparam int IIW = $clog2(N_IN);

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_DRAIN} state_t;

    state_t               r_state, w_state_next;
    logic [IIW-1:0]       r_in_idx, w_in_idx_next;
    logic [3:0]           r_out_idx, w_out_idx_next;
    logic [3:0]           r_cnt, w_cnt_next;
    logic                 r_err, w_err_next;
    logic                 w_in_fire, w_out_fire, w_in_end;
    logic [N_OUT*OUT_W-1:0] w_cap_flat;

    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = (r_state == S_DRAIN);
    assign busy       = (r_state != S_LOAD);
    assign err        = r_err;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_in_end   = (r_in_idx == IIW'(N_IN - 1));
    assign out_idx    = r_out_idx;
    assign out_last   = (r_out_idx == 4'(N_OUT - 1));
    assign out_data   = w_cap_flat[r_out_idx*OUT_W +: OUT_W];

    always_comb begin
        w_state_next   = r_state;
        w_in_idx_next  = r_in_idx;
        w_out_idx_next = r_out_idx;
        w_cnt_next     = r_cnt;
        w_err_next     = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_in_fire) begin
                    if (in_last && w_in_end) begin
                        w_state_next  = S_SETTLE;
                        w_in_idx_next = '0;
                        w_cnt_next    = 4'(SETTLE);
                    end else if (in_last || w_in_end) begin
                        // Framing error: drop the partial vector, keep slot contents.
                        w_err_next    = 1'b1;
                        w_in_idx_next = '0;
                    end else begin
                        w_in_idx_next = r_in_idx + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_CAPTURE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_CAPTURE: begin
                w_state_next   = S_DRAIN;
                w_out_idx_next = '0;
            end
            S_DRAIN: begin
                if (w_out_fire) begin
                    if (out_last) begin
                        w_state_next   = S_LOAD;
                        w_out_idx_next = '0;
                    end else begin
                        w_out_idx_next = r_out_idx + 4'd1;
                    end
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_in_idx  <= w_in_idx_next;
            r_out_idx <= w_out_idx_next;
            r_cnt     <= w_cnt_next;
            r_err     <= w_err_next;
        end
    end

    // layer_in comes straight from these slot registers so it stays glitch-free while settling.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_slot
            logic [IN_W-1:0] r_slot;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot <= '0;
                end else if (w_in_fire && (r_in_idx == IIW'(gi))) begin
                    r_slot <= in_data;
                end
            end
            assign layer_in[gi*IN_W +: IN_W] = r_slot;
        end

        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cap_slot
            logic [OUT_W-1:0] r_cap;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cap <= '0;
                end else if (r_state == S_CAPTURE) begin
                    r_cap <= layer_out[gi*OUT_W +: OUT_W];
                end
            end
            assign w_cap_flat[gi*OUT_W +: OUT_W] = r_cap;
        end
    endgenerate
endmodule
